// File: rtl/decoder_scan_sequencer_if.sv
// Handshake bundle between a scan controller and the decoder_scan_sequencer.
// The master drives control and mask; the slave returns the scanned code and status.
interface decoder_scan_sequencer_if;
    logic        start;
    logic        stop;
    logic        cont;
    logic [15:0] skip_mask;
    logic [3:0]  sel;
    logic        active;
    logic        done;
    logic        wrap;

    modport master (output start, stop, cont, skip_mask,
                    input  sel, active, done, wrap);
    modport slave  (input  start, stop, cont, skip_mask,
                    output sel, active, done, wrap);
endinterface

// File: rtl/decoder_scan_sequencer.sv
// Steps a 4-bit decoder select through the unmasked codes 0..15, holding each
// code DWELL clocks, with one-shot/continuous modes and done/wrap pulses.
module decoder_scan_sequencer #(
    parameter int DWELL   = 30,
    parameter int DWELL_W = 16
) (
    input logic                    clk,
    input logic                    rst,
    decoder_scan_sequencer_if.slave bus
);
    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [DWELL_W-1:0] LAST = DWELL_W'(DWELL - 1);

    state_t             state;
    logic [DWELL_W-1:0] cnt;
    logic               cont_q;
    logic [15:0]        mask_q;
    logic [3:0]         sel_q;
    logic               active_q;
    logic               done_q;
    logic               wrap_q;

    logic [15:0]        above;
    logic [4:0]         start_pick;
    logic [4:0]         wrap_pick;
    logic [4:0]         next_pick;

    // {found, code} of the lowest set bit
    function automatic logic [4:0] lowest(input logic [15:0] m);
        logic [4:0] r;
        r = 5'd0;
        for (int i = 15; i >= 0; i--)
            if (m[i]) r = {1'b1, 4'(i)};
        return r;
    endfunction

    always_comb begin
        above = '0;
        for (int i = 0; i < 16; i++)
            above[i] = (5'(i) > {1'b0, sel_q});
        start_pick = lowest(~bus.skip_mask);
        wrap_pick  = lowest(~mask_q);
        next_pick  = lowest(~mask_q & above);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cont_q   <= 1'b0;
            mask_q   <= '0;
            sel_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.stop && bus.start) begin
                        if (!start_pick[4]) begin
                            done_q <= 1'b1;
                        end else begin
                            cont_q   <= bus.cont;
                            mask_q   <= bus.skip_mask;
                            sel_q    <= start_pick[3:0];
                            cnt      <= '0;
                            active_q <= 1'b1;
                            state    <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (bus.stop) begin
                        state    <= IDLE;
                        sel_q    <= '0;
                        active_q <= 1'b0;
                        cnt      <= '0;
                    end else if (cnt == LAST) begin
                        cnt <= '0;
                        if (next_pick[4]) begin
                            sel_q <= next_pick[3:0];
                        end else if (cont_q) begin
                            sel_q  <= wrap_pick[3:0];
                            wrap_q <= 1'b1;
                        end else begin
                            state    <= IDLE;
                            sel_q    <= '0;
                            active_q <= 1'b0;
                            done_q   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + DWELL_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sel    = sel_q;
    assign bus.active = active_q;
    assign bus.done   = done_q;
    assign bus.wrap   = wrap_q;
endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Drives three sequencers (DWELL=1,2,3) from one stimulus stream and checks each
// against a visit-list model every cycle, plus directed literal expectations.
module tb_decoder_scan_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, cont = 1'b0;
    logic [15:0] mask = '0;

    int vecs = 0;
    int errs = 0;

    decoder_scan_sequencer_if bus1 ();
    decoder_scan_sequencer_if bus2 ();
    decoder_scan_sequencer_if bus3 ();

    assign bus1.start = start; assign bus1.stop = stop; assign bus1.cont = cont; assign bus1.skip_mask = mask;
    assign bus2.start = start; assign bus2.stop = stop; assign bus2.cont = cont; assign bus2.skip_mask = mask;
    assign bus3.start = start; assign bus3.stop = stop; assign bus3.cont = cont; assign bus3.skip_mask = mask;

    decoder_scan_sequencer #(.DWELL(1), .DWELL_W(4))  u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    decoder_scan_sequencer #(.DWELL(2), .DWELL_W(16)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    decoder_scan_sequencer #(.DWELL(3), .DWELL_W(8))  u3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    always #5 clk = ~clk;

    logic [3:0] a_sel [3];
    logic       a_act [3], a_done [3], a_wrap [3];
    assign a_sel[0] = bus1.sel; assign a_act[0] = bus1.active; assign a_done[0] = bus1.done; assign a_wrap[0] = bus1.wrap;
    assign a_sel[1] = bus2.sel; assign a_act[1] = bus2.active; assign a_done[1] = bus2.done; assign a_wrap[1] = bus2.wrap;
    assign a_sel[2] = bus3.sel; assign a_act[2] = bus3.active; assign a_done[2] = bus3.done; assign a_wrap[2] = bus3.wrap;

    // Model: a scan is a list of codes to visit; each is shown for dw cycles.
    int         dw [3] = '{1, 2, 3};
    bit         m_run [3];
    bit         m_cont [3];
    int         m_list [3][16];
    int         m_n [3], m_idx [3], m_age [3];
    logic [3:0] e_sel [3] = '{0, 0, 0};
    logic       e_act [3] = '{0, 0, 0};
    logic       e_done [3] = '{0, 0, 0};
    logic       e_wrap [3] = '{0, 0, 0};

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            e_done[k] = 1'b0;
            e_wrap[k] = 1'b0;
            if (rst) begin
                m_run[k] = 0; m_cont[k] = 0;
            end else if (!m_run[k]) begin
                if (start && !stop) begin
                    m_n[k] = 0;
                    for (int c = 0; c < 16; c++)
                        if (!mask[c]) begin m_list[k][m_n[k]] = c; m_n[k]++; end
                    if (m_n[k] == 0) e_done[k] = 1'b1;
                    else begin
                        m_run[k] = 1; m_cont[k] = cont; m_idx[k] = 0; m_age[k] = 1;
                    end
                end
            end else if (stop) begin
                m_run[k] = 0;
            end else if (m_age[k] == dw[k]) begin
                m_age[k] = 1;
                if (m_idx[k] + 1 < m_n[k]) m_idx[k]++;
                else if (m_cont[k]) begin m_idx[k] = 0; e_wrap[k] = 1'b1; end
                else begin m_run[k] = 0; e_done[k] = 1'b1; end
            end else begin
                m_age[k]++;
            end
            e_act[k] = m_run[k];
            e_sel[k] = m_run[k] ? 4'(m_list[k][m_idx[k]]) : 4'd0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d.sel", k + 1),    32'(a_sel[k]),  32'(e_sel[k]));
            chk($sformatf("u%0d.active", k + 1), 32'(a_act[k]),  32'(e_act[k]));
            chk($sformatf("u%0d.done", k + 1),   32'(a_done[k]), 32'(e_done[k]));
            chk($sformatf("u%0d.wrap", k + 1),   32'(a_wrap[k]), 32'(e_wrap[k]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int n_act, n_done, n_wrap;

    initial begin
        // reset with start held
        rst = 1'b1; start = 1'b1;
        tick(); tick();
        chk("rst_sel", 32'(bus2.sel), 0);
        chk("rst_active", 32'(bus2.active), 0);
        chk("rst_done", 32'(bus1.done), 0);
        chk("rst_wrap", 32'(bus3.wrap), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_sel", 32'(bus2.sel), 0);
        chk("post_rst_active", 32'(bus2.active), 1);
        start = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        // one-shot, full mask open
        start = 1'b1; n_act = 0; n_done = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 0) start = 1'b0;
            if (bus2.active) n_act++;
            if (bus2.done) n_done++;
            if (c < 32) chk("os_sel", 32'(bus2.sel), 32'(c / 2));
            if (c == 32) chk("os_done_cycle", 32'({bus2.done, bus2.active, bus2.sel}), 32'h20);
        end
        chk("os_active_cycles", 32'(n_act), 32);
        chk("os_done_count", 32'(n_done), 1);
        stop = 1'b1; tick(); stop = 1'b0;

        // continuous over codes 0..3
        mask = 16'hFFF0; cont = 1'b1; start = 1'b1; n_wrap = 0; n_done = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (c == 0) start = 1'b0;
            chk("skip_sel", 32'(bus1.sel), 32'(c % 4));
            if (bus1.wrap) n_wrap++;
            if (bus1.done) n_done++;
        end
        chk("skip_wraps", 32'(n_wrap), 4);
        chk("skip_no_done", 32'(n_done), 0);
        cont = 1'b0; mask = 16'h0000;
        stop = 1'b1; tick(); stop = 1'b0;

        // stop in the middle of code 5 on the DWELL=3 unit
        start = 1'b1;
        for (int c = 0; c < 17; c++) begin
            tick();
            if (c == 0) start = 1'b0;
        end
        chk("stop_pre_sel", 32'(bus3.sel), 5);
        stop = 1'b1;
        tick();
        chk("stop_after", 32'({bus3.done, bus3.active, bus3.sel}), 0);
        start = 1'b1;
        tick(); tick(); tick();
        chk("start_stop_idle", 32'(bus3.active), 0);
        start = 1'b0; stop = 1'b0;
        tick();

        // everything masked
        mask = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        chk("allmask_done", 32'(bus1.done), 1);
        chk("allmask_active", 32'(bus1.active), 0);
        tick();
        chk("allmask_done_clear", 32'(bus1.done), 0);

        // back-to-back one-shot on code 15 only
        mask = 16'h7FFF; start = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("b2b_active", 32'(bus1.active), 32'((c % 2) == 0));
            chk("b2b_done", 32'(bus1.done), 32'((c % 2) == 1));
            if (c % 2 == 0) chk("b2b_sel", 32'(bus1.sel), 15);
        end
        start = 1'b0; stop = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Upstream driver for the decoder4_16 stage.
- Steps a 4-bit select code through 0..15 and holds each code for a programmable number of clocks.
- Code maps onto the decoder inputs as sel[3]=e, sel[2]=x, sel[1]=y, sel[0]=z.
- Supports per-code skip masking, one-shot or continuous scanning, start/stop control, and done/wrap status pulses for downstream logic.

Parameters:
DWELL, 30, clocks each selected code is held (legal 1..2**DWELL_W-1)
DWELL_W, 16, width of internal dwell counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  level; sampled in IDLE, begins a scan
stop  input  1  level; aborts an active scan
cont  input  1  1=continuous wrap, 0=one-shot; latched at start
skip_mask  input  16  bit i=1 skips code i; latched at start
sel  output  4  current code to decoder {e,x,y,z}
active  output  1  1 while sel is a valid scanned code
done  output  1  one-cycle pulse at end of a one-shot scan
wrap  output  1  one-cycle pulse when a continuous scan restarts

Behaviour:
- One clock domain; all outputs registered.
- Reset is synchronous and active-high. On rst, at the clock edge: state=IDLE, sel=0, active=0, done=0, wrap=0, dwell counter=0, latched cont and mask cleared.
- rst mid-scan wins over every other input.
- States are IDLE and SCAN.
- IDLE, sel=0, active=0:
  - stop=1: remain IDLE. stop has priority over a simultaneous start.
  - start=1 and stop=0, with all 16 mask bits set: done=1 for one cycle, remain IDLE.
  - start=1 and stop=0 otherwise:
    - Latch cont and skip_mask.
    - sel = lowest unmasked code; cnt=0; go to SCAN.
    - active=1 from the cycle after the start edge (1-cycle latency).
- SCAN, active=1:
  - cnt increments every clock.
  - stop=1: next edge goes to IDLE, sel=0, active=0, no done pulse. Stop takes priority over a simultaneous dwell expiry.
  - Dwell expiry is cnt==DWELL-1. On expiry, cnt returns to 0 and:
    - If an unmasked code greater than sel exists, sel = the smallest such code.
    - Else if latched cont=1, sel = lowest unmasked code, wrap=1 for one cycle, stay in SCAN.
    - Else go to IDLE: sel=0, active=0, done=1 for exactly one cycle.
- Each scanned code is held for exactly DWELL consecutive cycles.
- DWELL=1 advances the code every clock.
- A single unmasked code in continuous mode:
  - sel stays constant.
  - wrap pulses every DWELL cycles.
- start is ignored while in SCAN.
- skip_mask and cont changes during SCAN have no effect until the next start.
- A start held high after done immediately launches a new scan on the next edge: done and the new active=1 do not overlap, and active is low for exactly the done cycle.
- done and wrap are never asserted together. Neither is asserted while in reset.
- Next-code search is a combinational priority search over 16 bits (strictly greater than sel). No extra latency.

Test Plan:
- Reset: assert rst with start=1 for 2 cycles -> sel=0, active=0, done=0, wrap=0. Deassert -> scan starts next edge with sel=0, active=1.
- One-shot, DWELL=2, mask=0x0000, cont=0, start pulse:
  - sel holds 0,0,1,1,...,15,15 (32 active cycles).
  - Next cycle: active=0, sel=0, done=1 for one cycle.
- Skip mask, DWELL=1, mask=0xFFF0, cont=1:
  - sel sequence 0,1,2,3,0,1,...
  - wrap=1 in each cycle where sel returns to 0.
  - done never asserts.
- Stop mid-scan, DWELL=3:
  - Assert stop while sel=5 at cnt=1 -> next edge sel=0, active=0, done=0.
  - Assert start and stop together -> remains IDLE.
- All masked: mask=0xFFFF, start -> done=1 one cycle, active never asserts.
- Back-to-back: start held high, DWELL=1, cont=0, mask=0x7FFF:
  - sel=15 active 1 cycle, then done cycle with active=0.
  - Then sel=15, active=1 again, repeating with period 2.
